// File: rtl/alu_seq_hs_if.sv
// ============================================================================
//  Module      : alu_seq_hs_if
//  Description : Operand/result valid-ready bundle for the sequential ALU.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_seq_hs_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opc;
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic             inc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] w;
  logic             zer;
  logic             neg;
  logic             cry;
  logic             ovf;

  modport master (
    output in_valid, opc, ina, inb, inc, out_ready,
    input  in_ready, out_valid, w, zer, neg, cry, ovf
  );

  modport slave (
    input  in_valid, opc, ina, inb, inc, out_ready,
    output in_ready, out_valid, w, zer, neg, cry, ovf
  );
endinterface

`default_nettype wire

// File: rtl/alu_seq_hs.sv
// ============================================================================
//  Module      : alu_seq_hs
//  Description : Registered ALU with valid/ready handshakes and a shift-add
//                multiply on opc 111.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_hs #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  alu_seq_hs_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_w;
  logic             r_zer;
  logic             r_neg;
  logic             r_cry;
  logic             r_ovf;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_c;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_res_cry;
  logic             w_res_ovf;
  logic [WIDTH-1:0] w_mul_acc;

  assign bus.in_ready  = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.w         = r_w;
  assign bus.zer       = r_zer;
  assign bus.neg       = r_neg;
  assign bus.cry       = r_cry;
  assign bus.ovf       = r_ovf;

  // One shared adder serves every arithmetic opcode; negate is ~A + 1.
  always_comb begin
    w_add_a = bus.ina;
    w_add_b = '0;
    w_add_c = 1'b0;
    case (bus.opc)
      3'b000: begin
        w_add_a = ~bus.ina;
        w_add_c = 1'b1;
      end
      3'b001: w_add_c = 1'b1;
      3'b010: begin
        w_add_b = bus.inb;
        w_add_c = bus.inc;
      end
      3'b011: w_add_b = {bus.inb[WIDTH-1], bus.inb[WIDTH-1:1]};
      default: ;
    endcase
  end

  assign w_sum     = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_c};
  assign w_add_ovf = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != w_add_a[WIDTH-1]);

  always_comb begin
    w_res     = '0;
    w_res_cry = 1'b0;
    w_res_ovf = 1'b0;
    case (bus.opc)
      3'b000: begin
        w_res     = w_sum[WIDTH-1:0];
        w_res_ovf = (bus.ina == c_MIN);
      end
      3'b001, 3'b010, 3'b011: begin
        w_res     = w_sum[WIDTH-1:0];
        w_res_cry = w_sum[WIDTH];
        w_res_ovf = w_add_ovf;
      end
      3'b100:  w_res = bus.ina & bus.inb;
      3'b101:  w_res = bus.ina | bus.inb;
      3'b110:  w_res = {bus.ina[WIDTH/2-1:0], bus.inb[WIDTH/2-1:0]};
      default: ;
    endcase
  end

  assign w_mul_acc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_w         <= '0;
      r_zer       <= 1'b0;
      r_neg       <= 1'b0;
      r_cry       <= 1'b0;
      r_ovf       <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      // A drain clears the slot; a result loading on the same edge overrides it.
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.opc == 3'b111) begin
              r_mcand  <= bus.ina;
              r_mplier <= bus.inb;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= S_MUL;
            end else begin
              r_w         <= w_res;
              r_zer       <= (w_res == '0);
              r_neg       <= w_res[WIDTH-1];
              r_cry       <= w_res_cry;
              r_ovf       <= w_res_ovf;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_mul_acc;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          // The output slot is always free here: entry required it to be free or draining.
          if (r_cnt == c_LAST) begin
            r_w         <= w_mul_acc;
            r_zer       <= (w_mul_acc == '0);
            r_neg       <= w_mul_acc[WIDTH-1];
            r_cry       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_hs.sv
// ============================================================================
//  Module      : tb_alu_seq_hs
//  Description : Scoreboard bench for alu_seq_hs at WIDTH=16.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_hs;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   n_pop;

  typedef logic [19:0] exp_t;  // {w, zer, neg, cry, ovf}
  exp_t sbq[$];

  alu_seq_hs_if #(.WIDTH(16)) bus ();

  alu_seq_hs #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic c);
    logic [15:0] r;
    logic [15:0] y;
    logic        cy;
    logic        ov;
    int          us;
    int          ss;
    longint      p;
    r  = '0;
    cy = 1'b0;
    ov = 1'b0;
    y  = '0;
    case (op)
      3'b000: begin
        ss = -int'($signed(a));
        r  = ss[15:0];
        ov = (ss > 32767);
      end
      3'b001, 3'b010, 3'b011: begin
        if (op == 3'b010) y = b;
        if (op == 3'b011) y = {b[15], b[15:1]};
        us = int'(a) + int'(y) + ((op == 3'b010) ? int'(c) : (op == 3'b001) ? 1 : 0);
        ss = int'($signed(a)) + int'($signed(y)) + ((op == 3'b010) ? int'(c) : (op == 3'b001) ? 1 : 0);
        r  = us[15:0];
        cy = (us > 65535);
        ov = (ss > 32767) || (ss < -32768);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = {a[7:0], b[7:0]};
      default: begin
        p = longint'(a) * longint'(b);
        r = p[15:0];
      end
    endcase
    return {r, (r == 16'h0000), r[15], cy, ov};
  endfunction

  // One clock: drive at negedge, resolve handshakes, then wait for the edge.
  task automatic drive_cycle(input logic iv, input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic c, input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.opc       = op;
    bus.ina       = a;
    bus.inb       = b;
    bus.inc       = c;
    bus.out_ready = ordy;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      check_eq("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check_eq("sb_result", {12'd0, bus.w, bus.zer, bus.neg, bus.cry, bus.ovf}, {12'd0, e});
        n_pop++;
      end
    end
    if (acc) sbq.push_back(model(op, a, b, c));
    @(posedge clk);
  endtask

  task automatic directed(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic c, input exp_t exp);
    logic acc;
    drive_cycle(1'b1, op, a, b, c, 1'b0, acc);
    @(negedge clk);
    #1;
    check_eq({tag, "_acc"}, 32'(acc), 32'd1);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_res"}, {12'd0, bus.w, bus.zer, bus.neg, bus.cry, bus.ovf}, {12'd0, exp});
    drive_cycle(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 1'b1, acc);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic acc;
    logic a1;
    logic a2;
    int   first_valid;
    int   busy;
    int   p0;
    int   n_acc;

    n_tests = 0;
    n_fail  = 0;
    n_pop   = 0;
    rst_n   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opc       = 3'b000;
    bus.ina       = '0;
    bus.inb       = '0;
    bus.inc       = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_state", {12'd0, bus.w, bus.zer, bus.neg, bus.cry, bus.ovf}, 32'd0);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    directed("add_ovf", 3'b010, 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    directed("addc",    3'b010, 16'hFFFF, 16'h0000, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    directed("ash_add", 3'b011, 16'h0010, 16'hFFF0, 1'b0, {16'h0008, 1'b0, 1'b0, 1'b1, 1'b0});
    directed("concat",  3'b110, 16'h12AB, 16'h34CD, 1'b0, {16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0});
    directed("neg_0",   3'b000, 16'h0000, 16'h0000, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    directed("neg_min", 3'b000, 16'h8000, 16'h0000, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    directed("inc_max", 3'b001, 16'hFFFF, 16'h0000, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    directed("inc_ovf", 3'b001, 16'h7FFF, 16'h0000, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    directed("and",     3'b100, 16'hF0F0, 16'h3C3C, 1'b0, {16'h3030, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("or",      3'b101, 16'hF0F0, 16'h0C0C, 1'b0, {16'hFCFC, 1'b0, 1'b1, 1'b0, 1'b0});

    // Multiply latency: the accept edge plus sixteen iteration edges.
    drive_cycle(1'b1, 3'b111, 16'hFFFD, 16'h0007, 1'b0, 1'b0, acc);
    check_eq("mul_acc", 32'(acc), 32'd1);
    first_valid = -1;
    busy        = 0;
    for (int j = 0; j < 40 && first_valid < 0; j++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) first_valid = j;
      else if (!bus.in_ready) busy++;
    end
    check_eq("mul_latency", 32'(first_valid), 32'd16);
    check_eq("mul_busy", 32'(busy), 32'd16);
    check_eq("mul_res", {12'd0, bus.w, bus.zer, bus.neg, bus.cry, bus.ovf},
             {12'd0, 16'hFFEB, 1'b0, 1'b1, 1'b0, 1'b0});
    drive_cycle(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 1'b1, acc);

    // Backpressure: second beat is refused and the first result is held.
    drive_cycle(1'b1, 3'b001, 16'h0000, 16'h0, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 3'b001, 16'h0001, 16'h0, 1'b0, 1'b0, acc);
    check_eq("bp_refused", 32'(acc), 32'd0);
    @(negedge clk);
    #1;
    check_eq("bp_hold_w", {16'd0, bus.w}, 32'h0001);
    check_eq("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    check_eq("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    p0 = n_pop;
    drive_cycle(1'b1, 3'b001, 16'h0001, 16'h0, 1'b0, 1'b1, a1);
    drive_cycle(1'b1, 3'b001, 16'h0002, 16'h0, 1'b0, 1'b1, a2);
    drive_cycle(1'b0, 3'b001, 16'h0000, 16'h0, 1'b0, 1'b1, acc);
    check_eq("bp_stream_acc", {30'd0, a1, a2}, 32'd3);
    check_eq("bp_stream_pops", 32'(n_pop - p0), 32'd3);
    check_eq("bp_stream_empty", 32'(sbq.size()), 32'd0);

    // Asynchronous reset in the middle of a multiply.
    drive_cycle(1'b1, 3'b111, 16'h0003, 16'h0005, 1'b0, 1'b1, acc);
    repeat (7) drive_cycle(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    @(negedge clk);
    #1;
    check_eq("rstm_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rstm_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rstm_w", {16'd0, bus.w}, 32'd0);
    check_eq("rstm_idle", 32'(bus.in_ready), 32'd1);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    p0 = n_pop;
    drive_cycle(1'b1, 3'b111, 16'h0003, 16'h0005, 1'b0, 1'b1, acc);
    for (int j = 0; j < 40 && n_pop == p0; j++)
      drive_cycle(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    check_eq("rstm_after_pops", 32'(n_pop - p0), 32'd1);

    // Random traffic against the model.
    n_acc = 0;
    for (int cyc = 0; cyc < 60000 && n_acc < 4000; cyc++) begin
      drive_cycle(($urandom_range(0, 9) < 7), 3'($urandom), pick(), pick(), 1'($urandom),
                  ($urandom_range(0, 9) < 7), acc);
      if (acc) n_acc++;
    end
    check_eq("rand_beats", 32'(n_acc), 32'd4000);
    for (int j = 0; j < 100 && (sbq.size() != 0 || bus.out_valid); j++)
      drive_cycle(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    check_eq("rand_drained", 32'(sbq.size()), 32'd0);
    check_eq("rand_idle", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
